// File: rtl/adder_arbiter_if.sv
// Requester-side bus of the adder arbiter: two operand request channels and the shared response.
interface adder_arbiter_if #(
    parameter int WIDTH = 64
);
    logic             req0_valid;
    logic             req1_valid;
    logic [WIDTH-1:0] req0_a;
    logic [WIDTH-1:0] req0_b;
    logic [WIDTH-1:0] req1_a;
    logic [WIDTH-1:0] req1_b;
    logic             req0_ready;
    logic             req1_ready;
    logic             rsp0_valid;
    logic             rsp1_valid;
    logic [WIDTH:0]   rsp_sum;

    modport master (
        output req0_valid, req1_valid, req0_a, req0_b, req1_a, req1_b,
        input  req0_ready, req1_ready, rsp0_valid, rsp1_valid, rsp_sum
    );

    modport slave (
        input  req0_valid, req1_valid, req0_a, req0_b, req1_a, req1_b,
        output req0_ready, req1_ready, rsp0_valid, rsp1_valid, rsp_sum
    );
endinterface

// File: rtl/adder_arbiter.sv
// Round-robin arbiter sharing one external pipelined adder between two requesters,
// with a tag pipeline that routes each result back to the requester that issued it.
module adder_arbiter #(
    parameter int WIDTH   = 64,
    parameter int LATENCY = 2
) (
    input  logic             clock,
    input  logic             reset,
    adder_arbiter_if.slave   bus,
    input  logic             hold,
    output logic [WIDTH-1:0] adder_a,
    output logic [WIDTH-1:0] adder_b,
    input  logic [WIDTH:0]   adder_sum,
    output logic             idle
);

    logic               r_last_gnt;
    logic [WIDTH-1:0]   r_adder_a_p0;
    logic [WIDTH-1:0]   r_adder_b_p0;
    logic               r_iss_vld_p0;
    logic               r_iss_id_p0;
    logic [LATENCY-1:0] r_tag_vld;
    logic [LATENCY-1:0] r_tag_id;
    logic               r_rsp0_vld;
    logic               r_rsp1_vld;
    logic [WIDTH:0]     r_rsp_sum;

    logic w_gnt0;
    logic w_gnt1;
    logic w_xfer;
    logic w_out_vld;
    logic w_out_id;

    // r_last_gnt high means requester 1 won last, so a tie goes to requester 0
    assign w_gnt0 = reset & ~hold & bus.req0_valid & (~bus.req1_valid | r_last_gnt);
    assign w_gnt1 = reset & ~hold & bus.req1_valid & (~bus.req0_valid | ~r_last_gnt);
    assign w_xfer = w_gnt0 | w_gnt1;

    assign w_out_vld = r_tag_vld[LATENCY-1];
    assign w_out_id  = r_tag_id[LATENCY-1];

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_last_gnt   <= 1'b1;
            r_adder_a_p0 <= '0;
            r_adder_b_p0 <= '0;
            r_iss_vld_p0 <= 1'b0;
            r_iss_id_p0  <= 1'b0;
            r_tag_vld    <= '0;
            r_tag_id     <= '0;
            r_rsp0_vld   <= 1'b0;
            r_rsp1_vld   <= 1'b0;
            r_rsp_sum    <= '0;
        end else begin
            // Issue stage: operands registered toward the adder
            if (w_xfer) begin
                r_last_gnt   <= w_gnt1;
                r_adder_a_p0 <= w_gnt1 ? bus.req1_a : bus.req0_a;
                r_adder_b_p0 <= w_gnt1 ? bus.req1_b : bus.req0_b;
            end
            r_iss_vld_p0 <= w_xfer;
            r_iss_id_p0  <= w_gnt1;

            // Tag stages: the issue-stage tag enters here as the operands enter the adder,
            // so the last stage lines up with the matching adder_sum
            r_tag_vld[0] <= r_iss_vld_p0;
            r_tag_id[0]  <= r_iss_id_p0;
            for (int i = 1; i < LATENCY; i++) begin
                r_tag_vld[i] <= r_tag_vld[i-1];
                r_tag_id[i]  <= r_tag_id[i-1];
            end

            // Response stage
            r_rsp0_vld <= w_out_vld & ~w_out_id;
            r_rsp1_vld <= w_out_vld & w_out_id;
            if (w_out_vld) begin
                r_rsp_sum <= adder_sum;
            end
        end
    end

    assign bus.req0_ready = w_gnt0;
    assign bus.req1_ready = w_gnt1;
    assign bus.rsp0_valid = r_rsp0_vld;
    assign bus.rsp1_valid = r_rsp1_vld;
    assign bus.rsp_sum    = r_rsp_sum;
    assign adder_a        = r_adder_a_p0;
    assign adder_b        = r_adder_b_p0;
    assign idle           = ~(r_iss_vld_p0 | (|r_tag_vld) | r_rsp0_vld | r_rsp1_vld);

endmodule

// File: tb/tb_adder_arbiter.sv
// Bench for adder_arbiter: directed scenarios plus random traffic against a
// transaction-level model (grant rule, per-operation due cycle, expected sum).
module tb_adder_arbiter;
    localparam int W = 64;
    localparam int L = 2;

    logic         clock;
    logic         reset;
    logic         hold;
    logic [W-1:0] adder_a;
    logic [W-1:0] adder_b;
    logic [W:0]   adder_sum;
    logic         idle;

    adder_arbiter_if #(.WIDTH(W)) bus ();

    adder_arbiter #(.WIDTH(W), .LATENCY(L)) dut (
        .clock     (clock),
        .reset     (reset),
        .bus       (bus),
        .hold      (hold),
        .adder_a   (adder_a),
        .adder_b   (adder_b),
        .adder_sum (adder_sum),
        .idle      (idle)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Behavioural pipelined adder: result appears L edges after its operands change
    logic [W:0] add_pipe [L];
    always @(posedge clock) begin
        add_pipe[0] <= {1'b0, adder_a} + {1'b0, adder_b};
        for (int i = 1; i < L; i++) add_pipe[i] <= add_pipe[i-1];
    end
    assign adder_sum = add_pipe[L-1];

    typedef struct {
        int         issue;
        int         due;
        bit         id;
        logic [W:0] sum;
    } op_t;

    op_t          pend[$];
    bit           m_last;
    logic [W:0]   m_rsp;
    logic [W-1:0] m_aa;
    logic [W-1:0] m_ab;
    int           cyc;
    bit           tx0;
    bit           tx1;
    int           total;
    int           bad;

    task automatic chk(input string tag, input logic [W:0] obs, input logic [W:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s got=%h want=%h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // One cycle: check outputs mid-cycle against the model, then advance the model across the edge
    task automatic step();
        bit   e_r0, e_r1, e_v0, e_v1, e_idle;
        op_t  e;
        @(negedge clock);
        e_r0 = bus.req0_valid && !hold && (!bus.req1_valid || m_last);
        e_r1 = bus.req1_valid && !hold && (!bus.req0_valid || !m_last);
        chk("req0_ready", {64'b0, bus.req0_ready}, {64'b0, e_r0});
        chk("req1_ready", {64'b0, bus.req1_ready}, {64'b0, e_r1});
        chk("adder_a", {1'b0, adder_a}, {1'b0, m_aa});
        chk("adder_b", {1'b0, adder_b}, {1'b0, m_ab});
        e_idle = 1'b1;
        foreach (pend[i]) if (pend[i].issue < cyc) e_idle = 1'b0;
        e_v0 = 1'b0;
        e_v1 = 1'b0;
        if (pend.size() > 0 && pend[0].due == cyc) begin
            e     = pend.pop_front();
            e_v0  = !e.id;
            e_v1  = e.id;
            m_rsp = e.sum;
        end
        chk("rsp0_valid", {64'b0, bus.rsp0_valid}, {64'b0, e_v0});
        chk("rsp1_valid", {64'b0, bus.rsp1_valid}, {64'b0, e_v1});
        chk("rsp_sum", bus.rsp_sum, m_rsp);
        chk("idle", {64'b0, idle}, {64'b0, e_idle});
        if (e_r0) begin
            pend.push_back('{cyc, cyc + L + 2, 1'b0, {1'b0, bus.req0_a} + {1'b0, bus.req0_b}});
            m_aa   = bus.req0_a;
            m_ab   = bus.req0_b;
            m_last = 1'b0;
        end else if (e_r1) begin
            pend.push_back('{cyc, cyc + L + 2, 1'b1, {1'b0, bus.req1_a} + {1'b0, bus.req1_b}});
            m_aa   = bus.req1_a;
            m_ab   = bus.req1_b;
            m_last = 1'b1;
        end
        tx0 = e_r0;
        tx1 = e_r1;
        cyc++;
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        #1;
        chk("rst_req0_ready", {64'b0, bus.req0_ready}, 65'd0);
        chk("rst_req1_ready", {64'b0, bus.req1_ready}, 65'd0);
        chk("rst_rsp0_valid", {64'b0, bus.rsp0_valid}, 65'd0);
        chk("rst_rsp1_valid", {64'b0, bus.rsp1_valid}, 65'd0);
        chk("rst_rsp_sum", bus.rsp_sum, 65'd0);
        chk("rst_adder_a", {1'b0, adder_a}, 65'd0);
        chk("rst_adder_b", {1'b0, adder_b}, 65'd0);
        chk("rst_idle", {64'b0, idle}, 65'd1);
        @(posedge clock);
        @(posedge clock);
        #1;
        reset  = 1'b1;
        pend.delete();
        m_last = 1'b1;
        m_rsp  = '0;
        m_aa   = '0;
        m_ab   = '0;
        tx0    = 1'b0;
        tx1    = 1'b0;
    endtask

    task automatic set_req(input bit v0, input logic [W-1:0] a0, input logic [W-1:0] b0,
                           input bit v1, input logic [W-1:0] a1, input logic [W-1:0] b1);
        bus.req0_valid = v0;
        bus.req0_a     = a0;
        bus.req0_b     = b0;
        bus.req1_valid = v1;
        bus.req1_a     = a1;
        bus.req1_b     = b1;
    endtask

    function automatic logic [W-1:0] rnd_op();
        case ($urandom_range(0, 5))
            0:       return '1;
            1:       return '0;
            default: return {$urandom, $urandom};
        endcase
    endfunction

    initial begin
        total = 0;
        bad   = 0;
        cyc   = 0;
        hold  = 1'b0;
        set_req(1'b1, 64'd5, 64'd6, 1'b1, 64'd7, 64'd8);
        do_reset();

        // Single request from requester 0
        set_req(1'b1, 64'h1, 64'h2, 1'b0, '0, '0);
        step();
        set_req(1'b0, '0, '0, 1'b0, '0, '0);
        repeat (6) step();

        // Carry-out from requester 1
        set_req(1'b0, '0, '0, 1'b1, '1, '1);
        step();
        set_req(1'b0, '0, '0, 1'b0, '0, '0);
        repeat (6) step();

        // Contention straight after reset: 0,1,0,1
        set_req(1'b1, 64'd1, 64'd1, 1'b1, 64'd2, 64'd2);
        do_reset();
        repeat (4) step();
        set_req(1'b0, '0, '0, 1'b0, '0, '0);
        repeat (6) step();

        // Hold with both valid after two issues
        set_req(1'b1, 64'd10, 64'd11, 1'b1, 64'd20, 64'd21);
        repeat (2) step();
        hold = 1'b1;
        repeat (3) step();
        hold = 1'b0;
        set_req(1'b0, '0, '0, 1'b0, '0, '0);
        repeat (6) step();

        // Reset while two operations are in flight
        set_req(1'b1, 64'd3, 64'd4, 1'b1, 64'd5, 64'd6);
        repeat (2) step();
        set_req(1'b0, '0, '0, 1'b0, '0, '0);
        step();
        do_reset();
        repeat (6) step();
        set_req(1'b1, 64'd9, 64'd9, 1'b1, 64'd8, 64'd8);
        step();
        set_req(1'b0, '0, '0, 1'b0, '0, '0);
        repeat (6) step();

        // Random traffic; an ungranted requester keeps its operands stable
        for (int k = 0; k < 10000; k++) begin
            if (!bus.req0_valid || tx0) begin
                bus.req0_valid = ($urandom_range(0, 3) != 0);
                bus.req0_a     = rnd_op();
                bus.req0_b     = rnd_op();
            end
            if (!bus.req1_valid || tx1) begin
                bus.req1_valid = ($urandom_range(0, 3) != 0);
                bus.req1_a     = rnd_op();
                bus.req1_b     = rnd_op();
            end
            hold = ($urandom_range(0, 4) == 0);
            step();
        end
        hold = 1'b0;
        set_req(1'b0, '0, '0, 1'b0, '0, '0);
        repeat (8) step();
        chk("drain_pending", 65'(pend.size()), 65'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
